// File: rtl/bitbang_multi.sv
// Serial configuration receiver: a host bit-bangs s_clk/s_data, and magic-tagged control words
// load one of NUM_CH parallel data registers, clear them all, or switch the block off.
module bitbang_multi #(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 3,
    parameter int NUM_CH      = 4
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           s_clk,
    input  logic                           s_data,
    output logic [NUM_CH*DATA_WIDTH-1:0]   data,
    output logic [NUM_CH-1:0]              strobe,
    output logic                           active,
    output logic                           bad_cmd
);

    localparam int                WARM_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES);
    localparam logic [WARM_W-1:0] WARM_ONE  = WARM_W'(1);
    localparam logic [11:0]       MAGIC     = 12'hFAB;
    localparam logic [3:0]        CMD_OFF   = 4'h0;
    localparam logic [3:0]        CMD_CLEAR = 4'hF;

    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] sdata_sync_r;
    logic [WARM_W-1:0]      warm_r;
    logic                   rise_r;
    logic                   fall_r;
    logic                   bit_r;
    logic [DATA_WIDTH-1:0]  ser_data_r;
    logic [15:0]            ser_ctrl_r;
    logic                   match_q_r;
    logic                   match_prev_r;
    logic [3:0]             cmd_q_r;
    logic [DATA_WIDTH-1:0]  data_q_r;

    logic                   edge_en_s;
    logic                   rise_s;
    logic                   fall_s;
    logic                   match_s;
    logic                   fire_s;
    logic [NUM_CH-1:0]      load_sel_s;
    logic                   load_any_s;

    // Input synchronisers; index SYNC_STAGES-1 is the oldest (most settled) stage.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sclk_sync_r  <= '0;
            sdata_sync_r <= '0;
        end else begin
            sclk_sync_r  <= {sclk_sync_r[SYNC_STAGES-2:0], s_clk};
            sdata_sync_r <= {sdata_sync_r[SYNC_STAGES-2:0], s_data};
        end
    end

    // Warm-up counter: holds off edge detection until the synchroniser holds real pin history.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            warm_r <= '0;
        end else if (warm_r != WARM_DONE) begin
            warm_r <= warm_r + WARM_ONE;
        end else begin
            warm_r <= warm_r;
        end
    end

    // Edge detection from the last two s_clk stages.
    always_comb begin
        edge_en_s = (warm_r == WARM_DONE);
        rise_s    = sclk_sync_r[SYNC_STAGES-2] & ~sclk_sync_r[SYNC_STAGES-1];
        fall_s    = ~sclk_sync_r[SYNC_STAGES-2] & sclk_sync_r[SYNC_STAGES-1];
        match_s   = (ser_ctrl_r[15:4] == MAGIC);
        fire_s    = match_q_r & ~match_prev_r;
    end

    // Registered edge pulses and the data bit that goes with them.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rise_r <= 1'b0;
            fall_r <= 1'b0;
            bit_r  <= 1'b0;
        end else begin
            rise_r <= edge_en_s & rise_s;
            fall_r <= edge_en_s & fall_s;
            bit_r  <= sdata_sync_r[SYNC_STAGES-1];
        end
    end

    // Shift registers: rising edges carry data bits, falling edges carry control bits.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ser_data_r <= '0;
            ser_ctrl_r <= '0;
        end else begin
            if (rise_r) begin
                ser_data_r <= {ser_data_r[DATA_WIDTH-2:0], bit_r};
            end else begin
                ser_data_r <= ser_data_r;
            end
            if (fall_r) begin
                ser_ctrl_r <= {ser_ctrl_r[14:0], bit_r};
            end else begin
                ser_ctrl_r <= ser_ctrl_r;
            end
        end
    end

    // Decode stage; data_q_r is captured alongside match_q_r so a concurrent shift cannot leak in.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            match_q_r    <= 1'b0;
            match_prev_r <= 1'b0;
            cmd_q_r      <= 4'h0;
            data_q_r     <= '0;
        end else begin
            match_q_r    <= match_s;
            match_prev_r <= match_q_r;
            cmd_q_r      <= ser_ctrl_r[3:0];
            data_q_r     <= ser_data_r;
        end
    end

    // One-hot channel select for load commands 1..NUM_CH.
    always_comb begin
        load_sel_s = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cmd_q_r == 4'(k + 1)) begin
                load_sel_s[k] = 1'b1;
            end else begin
                load_sel_s[k] = 1'b0;
            end
        end
        load_any_s = |load_sel_s;
    end

    // Command execution, once per rising edge of match_q_r.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data    <= '0;
            strobe  <= '0;
            active  <= 1'b0;
            bad_cmd <= 1'b0;
        end else begin
            strobe <= '0;
            if (fire_s) begin
                case (cmd_q_r)
                    CMD_OFF: begin
                        active  <= 1'b0;
                        bad_cmd <= 1'b0;
                    end
                    CMD_CLEAR: begin
                        data   <= '0;
                        strobe <= '1;
                    end
                    default: begin
                        if (load_any_s) begin
                            for (int k = 0; k < NUM_CH; k++) begin
                                if (load_sel_s[k]) begin
                                    data[k*DATA_WIDTH +: DATA_WIDTH] <= data_q_r;
                                end
                            end
                            strobe <= load_sel_s;
                            active <= 1'b1;
                        end else begin
                            bad_cmd <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule
